// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared types, default pattern constants and helpers for seq_gen.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int          c_def_pat_len = 4;
    localparam logic [3:0]  c_def_pat     = 4'b1101;

    // Zero (or an out-of-range request) selects the full word width.
    function automatic int eff_len(input int nbits, input int width);
        if (nbits == 0 || nbits > width) begin
            return width;
        end
        return nbits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match.sv
`default_nettype none
// ============================================================================
// Module   : seq_match
// Brief    : Sliding-window pattern compare and saturating match counter,
//            registered so exp_flag lines up with the bit entering dout.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = c_def_pat_len,
    parameter logic [PAT_LEN-1:0] PAT     = c_def_pat,
    parameter int                 CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr,
    output logic             exp_flag,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int c_seen_w = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0]  r_hist;
    logic [c_seen_w-1:0] r_seen;
    logic [PAT_LEN-1:0]  w_hist_base;
    logic [PAT_LEN-1:0]  w_hist_nxt;
    logic [c_seen_w-1:0] w_seen_base;
    logic [c_seen_w-1:0] w_seen_nxt;
    logic [CNT_W-1:0]    w_cnt_base;
    logic                w_hit;

    // clr arrives on the same edge as the first bit, so it masks the old state
    always_comb begin
        w_hist_base = clr ? '0 : r_hist;
        w_seen_base = clr ? '0 : r_seen;
        w_cnt_base  = clr ? '0 : match_cnt;
        w_hist_nxt  = {w_hist_base[PAT_LEN-2:0], bit_in};
        w_seen_nxt  = (w_seen_base == c_seen_w'(PAT_LEN)) ? w_seen_base
                                                          : w_seen_base + 1'b1;
        w_hit       = bit_valid && (w_seen_nxt == c_seen_w'(PAT_LEN))
                                && (w_hist_nxt == PAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist    <= '0;
            r_seen    <= '0;
            exp_flag  <= 1'b0;
            match_cnt <= '0;
        end else begin
            exp_flag <= w_hit;
            if (bit_valid) begin
                r_hist <= w_hist_nxt;
                r_seen <= w_seen_nxt;
            end else if (clr) begin
                r_hist <= '0;
                r_seen <= '0;
            end
            if (w_hit && (w_cnt_base != '1)) begin
                match_cnt <= w_cnt_base + 1'b1;
            end else begin
                match_cnt <= w_cnt_base;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen
// Brief    : MSB-first serial pattern generator with optional repeat, abort,
//            and a cycle-aligned golden pattern-seen flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen
    import seq_pkg::*;
#(
    parameter int                 WIDTH   = 32,
    parameter int                 PAT_LEN = c_def_pat_len,
    parameter logic [PAT_LEN-1:0] PAT     = c_def_pat,
    parameter int                 CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [$clog2(WIDTH+1)-1:0]   nbits,
    input  logic                         repeat_en,
    input  logic                         stop,
    output logic                         dout,
    output logic                         dout_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic                         exp_flag,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_word;
    logic [WIDTH-1:0]   w_word_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic [c_idx_w-1:0] r_last;
    logic [c_idx_w-1:0] w_last_nxt;
    logic               r_rep;
    logic               w_rep_nxt;
    logic [c_idx_w-1:0] w_load_last;
    logic [c_idx_w-1:0] w_idx_dec;
    logic               w_dout_nxt;
    logic               w_valid_nxt;
    logic               w_done_nxt;
    logic               w_aborted_nxt;
    logic               w_clr;

    assign w_load_last = c_idx_w'(eff_len(int'(nbits), WIDTH) - 1);
    assign w_idx_dec   = r_idx - 1'b1;

    // r_idx always names the bit currently on dout
    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_idx_nxt     = r_idx;
        w_last_nxt    = r_last;
        w_rep_nxt     = r_rep;
        w_dout_nxt    = 1'b0;
        w_valid_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_clr         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_word_nxt  = data_in;
                    w_last_nxt  = w_load_last;
                    w_idx_nxt   = w_load_last;
                    w_rep_nxt   = repeat_en;
                    w_clr       = 1'b1;
                    w_dout_nxt  = data_in[w_load_last];
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = (w_load_last == '0);
                end
            end
            SHIFT: begin
                if (stop) begin
                    w_state_nxt   = IDLE;
                    w_aborted_nxt = 1'b1;
                end else if (r_idx == '0) begin
                    if (r_rep) begin
                        w_idx_nxt   = r_last;
                        w_dout_nxt  = r_word[r_last];
                        w_valid_nxt = 1'b1;
                        w_done_nxt  = (r_last == '0);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_idx_nxt   = w_idx_dec;
                    w_dout_nxt  = r_word[w_idx_dec];
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = (w_idx_dec == '0);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_idx      <= '0;
            r_last     <= '0;
            r_rep      <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_idx      <= w_idx_nxt;
            r_last     <= w_last_nxt;
            r_rep      <= w_rep_nxt;
            dout       <= w_dout_nxt;
            dout_valid <= w_valid_nxt;
            busy       <= (w_state_nxt == SHIFT);
            done       <= w_done_nxt;
            aborted    <= w_aborted_nxt;
        end
    end

    // Fed with the bit about to be registered onto dout, keeping exp_flag aligned
    seq_match #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT),
        .CNT_W   (CNT_W)
    ) u_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (w_dout_nxt),
        .bit_valid (w_valid_nxt),
        .clr       (w_clr),
        .exp_flag  (exp_flag),
        .match_cnt (match_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_gen
// Brief    : Directed scoreboard bench for seq_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_in;
    logic [5:0]  nbits;
    logic        repeat_en;
    logic        stop;

    logic        dout, dout_valid, busy, done, aborted, exp_flag;
    logic [15:0] match_cnt;
    logic        d2_dout, d2_valid, d2_busy, d2_done, d2_aborted, d2_flag;
    logic [1:0]  d2_cnt;

    typedef struct packed {
        logic        dout;
        logic        valid;
        logic        done;
        logic        aborted;
        logic        busy;
        logic        flag;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    string       phase  = "reset";
    logic [3:0]  m_hist;
    int          m_seen;
    int          m_cnt;

    seq_gen dut (
        .clk (clk), .rst_n (rst_n), .start (start), .data_in (data_in),
        .nbits (nbits), .repeat_en (repeat_en), .stop (stop),
        .dout (dout), .dout_valid (dout_valid), .busy (busy), .done (done),
        .aborted (aborted), .exp_flag (exp_flag), .match_cnt (match_cnt)
    );

    seq_gen #(.PAT(4'b1111), .CNT_W(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .start (start), .data_in (data_in),
        .nbits (nbits), .repeat_en (repeat_en), .stop (stop),
        .dout (d2_dout), .dout_valid (d2_valid), .busy (d2_busy), .done (d2_done),
        .aborted (d2_aborted), .exp_flag (d2_flag), .match_cnt (d2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, expv);
        end
    endtask

    // Reference model of the pattern window for the default 1101 instance
    task automatic push_exp(input logic d, input logic v, input logic dn,
                            input logic ab, input logic clr);
        exp_t e;
        logic f;
        f = 1'b0;
        if (clr) begin
            m_hist = '0;
            m_seen = 0;
            m_cnt  = 0;
        end
        if (v) begin
            m_hist = {m_hist[2:0], d};
            if (m_seen < 4) m_seen++;
            f = (m_seen == 4) && (m_hist == 4'b1101);
            if (f && m_cnt < 65535) m_cnt++;
        end
        e.dout = d; e.valid = v; e.done = dn; e.aborted = ab;
        e.busy = v; e.flag = f; e.cnt = 16'(m_cnt);
        q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", phase);
        end else begin
            e = q.pop_front();
            chk("dout",       dout,       e.dout);
            chk("dout_valid", dout_valid, e.valid);
            chk("done",       done,       e.done);
            chk("aborted",    aborted,    e.aborted);
            chk("busy",       busy,       e.busy);
            chk("exp_flag",   exp_flag,   e.flag);
            chk("match_cnt",  match_cnt,  e.cnt);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [2:0]  p;
        rst_n = 1'b0; start = 1'b0; data_in = '0; nbits = '0;
        repeat_en = 1'b0; stop = 1'b0;
        m_hist = '0; m_seen = 0; m_cnt = 0;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", exp_flag, 0);
        chk("rst_cnt", match_cnt, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full 32-bit word, single pass
        phase = "word32";
        data_in = 32'hC646A4A2; nbits = 0; repeat_en = 1'b0; start = 1'b1;
        w = data_in;
        for (int k = 0; k < 32; k++) begin
            push_exp(w[31-k], 1'b1, k == 31, 1'b0, k == 0);
            cyc();
            start = 1'b0;
        end
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("final_cnt", match_cnt, 1);

        // 3-bit repeating word, ignored busy start, then stop
        phase = "repeat3";
        data_in = 32'h5; nbits = 3; repeat_en = 1'b1; start = 1'b1;
        p = 3'b101;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                start = 1'b1; data_in = 32'hFFFF0000; nbits = 7; repeat_en = 1'b0;
            end
            push_exp(p[2-(i%3)], 1'b1, (i % 3) == 2, 1'b0, i == 0);
            cyc();
            start = 1'b0;
        end
        stop = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        stop = 1'b0;
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("held_cnt", match_cnt, 2);

        // Single-bit word
        phase = "len1";
        data_in = 32'h1; nbits = 1; repeat_en = 1'b0; start = 1'b1;
        push_exp(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        start = 1'b0;
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Asynchronous reset in the middle of a stream
        phase = "rst_mid";
        data_in = 32'hDDDDDDDD; nbits = 0; start = 1'b1;
        w = data_in;
        for (int i = 0; i <= 10; i++) begin
            push_exp(w[31-i], 1'b1, 1'b0, 1'b0, i == 0);
            cyc();
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_dout", dout, 0);
        chk("async_valid", dout_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_aborted", aborted, 0);
        chk("async_flag", exp_flag, 0);
        chk("async_cnt", match_cnt, 0);
        #2 rst_n = 1'b1;

        phase = "after_rst";
        data_in = 32'h8; nbits = 4; start = 1'b1;
        w = data_in;
        for (int i = 0; i < 4; i++) begin
            push_exp(w[3-i], 1'b1, i == 3, 1'b0, i == 0);
            cyc();
            start = 1'b0;
        end
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // All-ones word: second instance watches 1111 with a 2-bit counter
        phase = "sat";
        data_in = 32'hFFFFFFFF; nbits = 0; start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            int ec;
            ec = (k < 3) ? 0 : ((k - 2 > 3) ? 3 : k - 2);
            push_exp(1'b1, 1'b1, k == 31, 1'b0, k == 0);
            cyc();
            start = 1'b0;
            chk("d2_dout", d2_dout, 1);
            chk("d2_valid", d2_valid, 1);
            chk("d2_busy", d2_busy, 1);
            chk("d2_done", d2_done, k == 31);
            chk("d2_aborted", d2_aborted, 0);
            chk("d2_flag", d2_flag, k >= 3);
            chk("d2_cnt", d2_cnt, ec);
        end
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("d2_idle_valid", d2_valid, 0);
        chk("d2_idle_cnt", d2_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
